// File: rtl/lif_pkg.sv
// Shared types and default sizing for the LIF timestep scheduler.
package lif_pkg;

   localparam int LIF_NUM_NEURONS_DEF = 8;
   localparam int LIF_NUM_STEPS_DEF   = 16;
   localparam int LIF_CNT_W_DEF       = 16;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ISSUE    = 2'd1,
      ST_STEP_END = 2'd2,
      ST_DONE     = 2'd3
   } lif_state_e;

endpackage

// File: rtl/lif_idx_counter.sv
// Up-counter with synchronous clear and enable; wraps to zero past TERM and
// flags when the count sits at TERM.
module lif_idx_counter #(
   parameter int          W    = 4,
   parameter logic [W-1:0] TERM = '1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         wrap_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (en_i)
         cnt_d = wrap_o ? '0 : cnt_q + W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = (cnt_q == TERM);

endmodule

// File: rtl/lif_step_scheduler.sv
// Sequences neuron updates through a shared LIF datapath, one timestep at a time.
// Define LIF_SCHED_STATS_EN to compile in the saturating spike tally.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   IDLE     | waiting for start
//   ISSUE    | presenting nrn_idx to the datapath until all accepted
//   STEP_END | one-cycle step_tick, advance or finish the run
//   DONE     | one-cycle done pulse, then back to IDLE
module lif_step_scheduler
   import lif_pkg::*;
#(
   parameter int NUM_NEURONS = LIF_NUM_NEURONS_DEF,
   parameter int NUM_STEPS   = LIF_NUM_STEPS_DEF,
   parameter int CNT_W       = LIF_CNT_W_DEF,
   localparam int NRN_W      = $clog2(NUM_NEURONS),
   localparam int STEP_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic              nrn_valid,
   input  logic              nrn_ready,
   output logic [NRN_W-1:0]  nrn_idx,
   output logic [STEP_W-1:0] step_idx,
   output logic              step_tick,
   input  logic              spike_vld,
   output logic [CNT_W-1:0]  spike_total,
   output logic              busy,
   output logic              done
);

   lif_state_e state_q, state_d;
   logic       run_clr;
   logic       nrn_wrap, step_wrap;
   logic       nrn_en, step_en;

   assign run_clr   = (state_q == ST_IDLE) && start;
   assign busy      = (state_q != ST_IDLE);
   assign nrn_valid = (state_q == ST_ISSUE);
   assign step_tick = (state_q == ST_STEP_END);
   assign done      = (state_q == ST_DONE);

   // abort blocks the handshake and the step advance on the same edge
   assign nrn_en  = nrn_valid && nrn_ready && !abort;
   assign step_en = step_tick && !step_wrap && !abort;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:     if (start) state_d = ST_ISSUE;
         ST_ISSUE:    if (nrn_ready && nrn_wrap) state_d = ST_STEP_END;
         ST_STEP_END: state_d = step_wrap ? ST_DONE : ST_ISSUE;
         ST_DONE:     state_d = ST_IDLE;
         default:     state_d = ST_IDLE;
      endcase
      if (abort && busy)
         state_d = ST_IDLE;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   lif_idx_counter #(
      .W    (NRN_W),
      .TERM (NRN_W'(NUM_NEURONS - 1))
   ) u_nrn_cnt (
      .clk    (clk),
      .rst_n  (rst),
      .clr_i  (run_clr),
      .en_i   (nrn_en),
      .cnt_o  (nrn_idx),
      .wrap_o (nrn_wrap)
   );

   lif_idx_counter #(
      .W    (STEP_W),
      .TERM (STEP_W'(NUM_STEPS - 1))
   ) u_step_cnt (
      .clk    (clk),
      .rst_n  (rst),
      .clr_i  (run_clr),
      .en_i   (step_en),
      .cnt_o  (step_idx),
      .wrap_o (step_wrap)
   );

`ifdef LIF_SCHED_STATS_EN
   logic [CNT_W-1:0] tally_q, tally_d;

   always_comb begin
      tally_d = tally_q;
      if (run_clr)
         tally_d = '0;
      else if (busy && spike_vld && !abort && (tally_q != '1))
         tally_d = tally_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         tally_q <= '0;
      else
         tally_q <= tally_d;
   end

   assign spike_total = tally_q;
`else
   logic unused_spike_vld;

   assign unused_spike_vld = spike_vld;
   assign spike_total      = '0;
`endif

endmodule

// File: tb/tb_lif_step_scheduler.sv
// Randomized and directed check of lif_step_scheduler against a run-level model
// that tracks handshakes completed and derives indices arithmetically.
module tb_lif_step_scheduler;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int CW = 2;

   logic       clk = 1'b0;
   logic       rst, start, abort, nrn_ready, spike_vld;
   logic       nrn_valid, step_tick, busy, done;
   logic [1:0] nrn_idx;
   logic [0:0] step_idx;
   logic [CW-1:0] spike_total;

   int n_total = 0;
   int n_bad   = 0;

   // model: phase 0 idle, 1 issuing, 2 end-of-step, 3 done
   int m_phase, m_hs, m_tally, m_nrn, m_step;

   always #5 clk = ~clk;

   lif_step_scheduler #(
      .NUM_NEURONS (N),
      .NUM_STEPS   (S),
      .CNT_W       (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .abort       (abort),
      .nrn_valid   (nrn_valid),
      .nrn_ready   (nrn_ready),
      .nrn_idx     (nrn_idx),
      .step_idx    (step_idx),
      .step_tick   (step_tick),
      .spike_vld   (spike_vld),
      .spike_total (spike_total),
      .busy        (busy),
      .done        (done)
   );

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_total++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp_v, $time);
      end
   endtask

   function automatic int exp_nrn();
      return (m_phase == 0) ? m_nrn : (m_hs % N);
   endfunction

   function automatic int exp_step();
      if (m_phase == 0) return m_step;
      if (m_phase == 1) return m_hs / N;
      return (m_hs - 1) / N;
   endfunction

   function automatic int exp_tally();
`ifdef LIF_SCHED_STATS_EN
      return m_tally;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_phase = 0; m_hs = 0; m_tally = 0; m_nrn = 0; m_step = 0;
   endtask

   task automatic model_edge();
      if (!rst) begin
         model_reset();
      end else if (m_phase == 0) begin
         if (start) begin
            m_phase = 1; m_hs = 0; m_tally = 0;
         end
      end else if (abort) begin
         m_nrn = exp_nrn(); m_step = exp_step(); m_phase = 0;
      end else begin
         if (spike_vld && m_tally < (1 << CW) - 1) m_tally++;
         case (m_phase)
            1: if (nrn_ready) begin
                  m_hs++;
                  if (m_hs % N == 0) m_phase = 2;
               end
            2: m_phase = (m_hs == N * S) ? 3 : 1;
            default: begin m_phase = 0; m_nrn = 0; m_step = S - 1; end
         endcase
      end
   endtask

   task automatic check_all();
      chk("busy",        int'(busy),        int'(m_phase != 0));
      chk("nrn_valid",   int'(nrn_valid),   int'(m_phase == 1));
      chk("step_tick",   int'(step_tick),   int'(m_phase == 2));
      chk("done",        int'(done),        int'(m_phase == 3));
      chk("nrn_idx",     int'(nrn_idx),     exp_nrn());
      chk("step_idx",    int'(step_idx),    exp_step());
      chk("spike_total", int'(spike_total), exp_tally());
   endtask

   // inputs are set before calling; one clock edge, then compare at negedge
   task automatic cyc();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
   endtask

   task automatic run_to_idle();
      int k = 0;
      start = 1'b0; abort = 1'b0;
      while (busy && k < 60) begin
         cyc();
         k++;
      end
      chk("idle_timeout", int'(busy), 0);
   endtask

   initial begin
      int hs_q[$];
      int ticks, lat, dones, k;
      int sat_exp[6];

      rst = 1'b0; start = 1'b0; abort = 1'b0; nrn_ready = 1'b0; spike_vld = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst = 1'b1;
      cyc();

      // full run with ready tied high
      nrn_ready = 1'b1;
      start = 1'b1; cyc(); start = 1'b0;
      lat = 1; ticks = 0;
      while (!done && lat < 40) begin
         if (nrn_valid && nrn_ready) hs_q.push_back(int'(nrn_idx));
         cyc();
         if (step_tick) ticks++;
         lat++;
      end
      chk("run_latency", lat, S * (N + 1) + 1);
      chk("step_ticks", ticks, S);
      chk("hs_count", hs_q.size(), N * S);
      foreach (hs_q[i]) chk("hs_idx", hs_q[i], i % N);
      run_to_idle();

      // backpressure at nrn_idx=2
      start = 1'b1; cyc(); start = 1'b0;
      k = 0;
      while (!(nrn_valid && nrn_idx == 2) && k < 20) begin cyc(); k++; end
      nrn_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_valid", int'(nrn_valid), 1);
         chk("stall_idx", int'(nrn_idx), 2);
      end
      nrn_ready = 1'b1; cyc();
      chk("stall_release_idx", int'(nrn_idx), 3);
      run_to_idle();

      // abort together with the last handshake of step 0
      start = 1'b1; cyc(); start = 1'b0;
      k = 0;
      while (!(nrn_valid && nrn_idx == 3) && k < 20) begin cyc(); k++; end
      chk("abort_setup_step", int'(step_idx), 0);
      abort = 1'b1; cyc(); abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_tick", int'(step_tick), 0);
      chk("abort_done", int'(done), 0);
      dones = 0;
      for (int i = 0; i < 4; i++) begin cyc(); dones += int'(done) + int'(step_tick); end
      chk("abort_quiet", dones, 0);

      // saturating tally, then cleared by a new start
`ifdef LIF_SCHED_STATS_EN
      sat_exp = '{1, 2, 3, 3, 3, 3};
`else
      sat_exp = '{0, 0, 0, 0, 0, 0};
`endif
      start = 1'b1; cyc(); start = 1'b0;
      spike_vld = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("tally_seq", int'(spike_total), sat_exp[i]);
      end
      spike_vld = 1'b0;
      run_to_idle();
      start = 1'b1; cyc(); start = 1'b0;
      chk("tally_cleared", int'(spike_total), 0);

      // asynchronous reset between edges mid-ISSUE
      cyc();
      #2 rst = 1'b0;
      #1 model_reset();
      check_all();
      chk("arst_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b1;
      cyc();
      start = 1'b1; cyc(); start = 1'b0;
      lat = 1;
      while (!done && lat < 40) begin cyc(); lat++; end
      chk("post_rst_latency", lat, S * (N + 1) + 1);
      run_to_idle();

      // start held through the whole run
      start = 1'b1;
      cyc();
      dones = 0; k = 0;
      while (!done && k < 40) begin cyc(); k++; end
      dones += int'(done);
      cyc();
      chk("held_idle_after_done", int'(busy), 0);
      cyc();
      chk("held_restart", int'(busy), 1);
      chk("held_one_done", dones, 1);
      start = 1'b0; abort = 1'b1; cyc(); abort = 1'b0;

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         rst       = ($urandom_range(0, 149) != 0);
         start     = ($urandom_range(0, 3) == 0);
         abort     = ($urandom_range(0, 29) == 0);
         nrn_ready = ($urandom_range(0, 3) != 0);
         spike_vld = $urandom_range(0, 1) == 1;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
